// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA timing generator.
// Holds the 640x480@60 (lowRes) and 800x600@56 (hiRes) timing sets,
// the axis-total helper and the coordinate width shared by all counters.
package vga_timing_pkg;

  // Counters and coordinate outputs are this wide; every axis total must fit.
  localparam int COORD_W = 10;

  // lowRes: 640x480 @ 60 Hz, 25 MHz pixel rate.
  localparam int LO_H_ACTIVE = 640;
  localparam int LO_H_FP     = 16;
  localparam int LO_H_SYNC   = 96;
  localparam int LO_H_BP     = 48;
  localparam int LO_V_ACTIVE = 480;
  localparam int LO_V_FP     = 10;
  localparam int LO_V_SYNC   = 2;
  localparam int LO_V_BP     = 33;

  // hiRes: 800x600 @ 56 Hz, 36 MHz pixel rate. Its line is exactly 1024
  // pixels, the largest total a 10-bit counter can walk.
  localparam int HI_H_ACTIVE = 800;
  localparam int HI_H_FP     = 24;
  localparam int HI_H_SYNC   = 72;
  localparam int HI_H_BP     = 128;
  localparam int HI_V_ACTIVE = 600;
  localparam int HI_V_FP     = 1;
  localparam int HI_V_SYNC   = 2;
  localparam int HI_V_BP     = 22;

  // Length of one axis period (line or frame) in counter steps.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  localparam int LO_H_TOTAL = h_total(LO_H_ACTIVE, LO_H_FP, LO_H_SYNC, LO_H_BP);
  localparam int LO_V_TOTAL = v_total(LO_V_ACTIVE, LO_V_FP, LO_V_SYNC, LO_V_BP);
  localparam int HI_H_TOTAL = h_total(HI_H_ACTIVE, HI_H_FP, HI_H_SYNC, HI_H_BP);
  localparam int HI_V_TOTAL = v_total(HI_V_ACTIVE, HI_V_FP, HI_V_SYNC, HI_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational decode of
// the active region and the sync pulse for that axis.
// Ports: clk/reset_n, step (advance one position); count, wrap (at last
// position), active (inside visible region), sync (at POL inside pulse).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = LO_H_ACTIVE,
  parameter int FP     = LO_H_FP,
  parameter int SYNC   = LO_H_SYNC,
  parameter int BP     = LO_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               step,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               active,
  output logic               sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > (1 << COORD_W)) begin : g_total_too_big
    $error("vga_axis_counter: axis total %0d does not fit in %0d bits", TOTAL, COORD_W);
  end

  // Decode boundaries are compared one bit wider so an end value of exactly
  // 2**COORD_W (sync running up to the last position) does not truncate.
  localparam logic [COORD_W:0] LAST_C       = (COORD_W+1)'(TOTAL - 1);
  localparam logic [COORD_W:0] ACTIVE_C     = (COORD_W+1)'(ACTIVE);
  localparam logic [COORD_W:0] SYNC_START_C = (COORD_W+1)'(ACTIVE + FP);
  localparam logic [COORD_W:0] SYNC_END_C   = (COORD_W+1)'(ACTIVE + FP + SYNC);

  logic [COORD_W-1:0] count_q, count_d;
  logic [COORD_W:0]   count_x;

  assign count_x = {1'b0, count_q};
  assign wrap    = (count_x == LAST_C);

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign active = (count_x < ACTIVE_C);
  assign sync   = ((count_x >= SYNC_START_C) && (count_x < SYNC_END_C)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks h/v counters on pix_en and presents
// registered pixel coordinates, visibility, sync levels and a frame strobe.
// Ports: clk, reset_n, pix_en in; hPixel, line, video_active, hSync, vSync,
// frame_start out. Outputs lag the counters by one pixel (one pix_en edge).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = LO_H_ACTIVE,
  parameter int H_FP     = LO_H_FP,
  parameter int H_SYNC   = LO_H_SYNC,
  parameter int H_BP     = LO_H_BP,
  parameter int V_ACTIVE = LO_V_ACTIVE,
  parameter int V_FP     = LO_V_FP,
  parameter int V_SYNC   = LO_V_SYNC,
  parameter int V_BP     = LO_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  output logic [COORD_W-1:0] hPixel,
  output logic [COORD_W-1:0] line,
  output logic               video_active,
  output logic               hSync,
  output logic               vSync,
  output logic               frame_start
);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, h_act, h_sync;
  logic               v_act, v_sync;
  logic               v_step;
  // Frame start is decoded from the counts, so the vertical wrap is not needed.
  logic               v_wrap_unused;

  // The vertical axis moves only on the pixel that ends a line.
  assign v_step = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (pix_en),
    .count  (h_cnt),
    .wrap   (h_wrap),
    .active (h_act),
    .sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (v_step),
    .count  (v_cnt),
    .wrap   (v_wrap_unused),
    .active (v_act),
    .sync   (v_sync)
  );

  logic [COORD_W-1:0] hpix_q, hpix_d;
  logic [COORD_W-1:0] line_q, line_d;
  logic               active_q, active_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               fstart_q, fstart_d;
  logic               vis;

  assign vis = h_act & v_act;

  // Outputs load from the pre-advance counts on the same edge the counters
  // move, so they describe the pixel the counters held before that edge.
  always_comb begin
    hpix_d   = hpix_q;
    line_d   = line_q;
    active_d = active_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    fstart_d = 1'b0;  // strobe drops on any edge that does not re-arm it
    if (pix_en) begin
      active_d = vis;
      hpix_d   = vis ? h_cnt : '0;
      line_d   = vis ? v_cnt : '0;
      hsync_d  = h_sync;
      vsync_d  = v_sync;
      fstart_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hpix_q   <= '0;
      line_q   <= '0;
      active_q <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      fstart_q <= 1'b0;
    end else begin
      hpix_q   <= hpix_d;
      line_q   <= line_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fstart_q <= fstart_d;
    end
  end

  assign hPixel       = hpix_q;
  assign line         = line_q;
  assign video_active = active_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign frame_start  = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny
// 16x11-total instance with active-high syncs share clock, reset and pix_en.
// Stimulus queues expected pixels; a monitor pops them on every pix_en edge.
module tb_vga_timing_gen;

  // Small timing set for instance B: line 16 pixels, frame 11 lines.
  localparam int BHA = 8, BHF = 2, BHS = 3, BHB = 3;
  localparam int BVA = 6, BVF = 1, BVS = 2, BVB = 2;
  localparam int AHT = 800, AVT = 525;
  localparam int BHT = 16,  BVT = 11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pix_en;
  logic [9:0] hp_a, ln_a, hp_b, ln_b;
  logic       va_a, hs_a, vs_a, fs_a;
  logic       va_b, hs_b, vs_b, fs_b;

  vga_timing_gen dut_a (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hPixel(hp_a), .line(ln_a), .video_active(va_a),
    .hSync(hs_a), .vSync(vs_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hPixel(hp_b), .line(ln_b), .video_active(va_b),
    .hSync(hs_b), .vSync(vs_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] hp;
    logic [9:0] ln;
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ah = 0, av = 0, bh = 0, bv = 0;
  bit   done = 1'b0;

  // Monitor state and aggregate counters.
  obs_t pa, pb, ca, cb, ea, eb;
  bit   en_prev = 1'b0, rst_prev = 1'b0;
  int   a_hs_edges = 0, a_hs_clks = 0, a_max_hp = 0;
  int   b_vs_edges = 0, b_since = 0, b_gap = 0, b_max_ln = 0, b_max_hp = 0;
  int   snap;

  function automatic obs_t model(input int h, input int v,
                                 input int ha, input int hf, input int hsw,
                                 input int va, input int vf, input int vsw,
                                 input bit hpol, input bit vpol);
    obs_t o;
    o.act = (h < ha) && (v < va);
    o.hp  = o.act ? 10'(h) : 10'd0;
    o.ln  = o.act ? 10'(v) : 10'd0;
    o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hpol : ~hpol;
    o.vs  = (v >= va + vf && v < va + vf + vsw) ? vpol : ~vpol;
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t rst_obs(input bit hpol, input bit vpol);
    obs_t o;
    o = '0;
    o.hs = ~hpol;
    o.vs = ~vpol;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got hp=%0d ln=%0d va=%b hs=%b vs=%b fs=%b, expected hp=%0d ln=%0d va=%b hs=%b vs=%b fs=%b",
               name, $time, act.hp, act.ln, act.act, act.hs, act.vs, act.fs,
               exp.hp, exp.ln, exp.act, exp.hs, exp.vs, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Raw input drive, no expectation (used while reset is held).
  task automatic drive(input bit en);
    @(posedge clk);
    #1 pix_en = en;
  endtask

  // Drive one cycle; an enabled cycle queues the pixel it will emit.
  task automatic pix(input bit en);
    drive(en);
    if (en) begin
      qa.push_back(model(ah, av, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
      qb.push_back(model(bh, bv, BHA, BHF, BHS, BVA, BVF, BVS, 1'b1, 1'b1));
      if (ah == AHT - 1) begin ah = 0; av = (av == AVT - 1) ? 0 : av + 1; end
      else ah++;
      if (bh == BHT - 1) begin bh = 0; bv = (bv == BVT - 1) ? 0 : bv + 1; end
      else bh++;
    end
  endtask

  // Let the monitor consume the last queued edge.
  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b1;
    pix_en  = 1'b0;
    #2 reset_n = 1'b0;
    pa = rst_obs(1'b0, 1'b0);
    pb = rst_obs(1'b1, 1'b1);
    fork
      begin : monitor
        while (!done) begin
          @(negedge clk or negedge reset_n);
          #1;
          ca = {hp_a, ln_a, va_a, hs_a, vs_a, fs_a};
          cb = {hp_b, ln_b, va_b, hs_b, vs_b, fs_b};
          if (!reset_n || !rst_prev) begin
            pa = rst_obs(1'b0, 1'b0);
            pb = rst_obs(1'b1, 1'b1);
            check("reset_a", ca, pa);
            check("reset_b", cb, pb);
            b_since = 0;
          end else if (en_prev) begin
            if (qa.size() == 0 || qb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL sb_underflow @%0t: pixel edge seen with no expected entry", $time);
            end else begin
              ea = qa.pop_front();
              eb = qb.pop_front();
              check("pixel_a", ca, ea);
              check("pixel_b", cb, eb);
              pa = ea;
              pb = eb;
            end
            if (!hs_a) a_hs_edges++;
            if (int'(hp_a) > a_max_hp) a_max_hp = int'(hp_a);
            if (vs_b) b_vs_edges++;
            if (int'(hp_b) > b_max_hp) b_max_hp = int'(hp_b);
            if (int'(ln_b) > b_max_ln) b_max_ln = int'(ln_b);
            b_since++;
            if (fs_b) begin b_gap = b_since; b_since = 0; end
          end else begin
            pa.fs = 1'b0;
            pb.fs = 1'b0;
            check("hold_a", ca, pa);
            check("hold_b", cb, pb);
          end
          if (reset_n && rst_prev && !hs_a) a_hs_clks++;
          en_prev  = pix_en;
          rst_prev = reset_n;
        end
      end
      begin : stimulus
        // Reset held with pix_en toggling: outputs stay at reset values.
        repeat (6) begin drive(1'b1); drive(1'b0); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        pix(1'b0);

        // First line of A at one pixel per clk.
        snap = a_hs_edges;
        repeat (800) pix(1'b1);
        pix(1'b0);
        settle();
        check_int("a_hsync_pixels_per_line", a_hs_edges - snap, 96);
        check_int("a_max_hpixel", a_max_hp, 639);

        // Several full frames of B.
        snap = b_vs_edges;
        repeat (352) pix(1'b1);
        pix(1'b0);
        settle();
        check_int("b_vsync_pixels_two_frames", b_vs_edges - snap, 64);
        check_int("b_frame_start_interval", b_gap, 176);
        check_int("b_max_line", b_max_ln, 5);
        check_int("b_max_hpixel", b_max_hp, 7);

        // Half rate: one full A line is 1600 clks; the window also holds one
        // sample of the last pixel before it (h=351, outside sync).
        snap = a_hs_clks;
        repeat (800) begin pix(1'b1); pix(1'b0); end
        settle();
        check_int("a_hsync_clks_half_rate", a_hs_clks - snap, 192);

        // Run B into the middle of a frame, then reset asynchronously.
        for (int i = 0; i < 200 && !(bv == 3 && bh == 5); i++) pix(1'b1);
        check_int("b_reached_mid_frame", bv * 100 + bh, 305);
        @(posedge clk);
        #1 pix_en = 1'b0;
        @(negedge clk);
        #3 reset_n = 1'b0;
        ah = 0; av = 0; bh = 0; bv = 0;
        repeat (2) begin drive(1'b1); drive(1'b0); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        pix(1'b0);
        pix(1'b0);
        repeat (20) pix(1'b1);
        pix(1'b0);
        settle();
        done = 1'b1;
      end
    join
    check_int("sb_drained_a", qa.size(), 0);
    check_int("sb_drained_b", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
